ent_scan_seq: RTL

ENT_SCAN_SEQ -- requirements
Module: ent_scan_seq

---
 rtl/ent_scan_seq_pkg.sv | 15 +
 rtl/ent_scan_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ent_scan_seq_pkg.sv
// Shared definitions for the entropy-source channel scanner and the top that owns the channel mux.
// Holds the scanner FSM encodings, the default channel count and the index width.
package ent_scan_seq_pkg;

    localparam int NUM_CH_DEFAULT = 13;
    localparam int IDX_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/ent_scan_seq.sv
// Steps the mux select through channels 0..NUM_CH-1, waits SETTLE cycles, then captures and presents each byte.
// Latency: the first byte is valid SETTLE cycles after start; each channel costs SETTLE+1 cycles at full throughput.
// Backpressure: out_valid/out_data/out_idx/sel hold while out_ready is low; the scan resumes on the accepting edge.
module ent_scan_seq
    import ent_scan_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] sel,
    input  logic [7:0] sal_in,
    output logic [7:0] out_data,
    output logic [3:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d       = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Sample on the SETTLE-th edge after sel last moved.
                if (cnt_q == LAST_CNT) begin
                    out_data_d  = sal_in;
                    out_idx_d   = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // sel is the registered channel index itself, so it only moves on a transfer edge.
    assign sel       = idx_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
